// File: rtl/rf80386_pkg.sv
// Shared rf80386 types: bus cycle type encoding and BIU arbiter state.
package rf80386_pkg;

  typedef enum logic [3:0] {
    CT_PASSIVE = 4'd0,
    CT_CODE    = 4'd1,
    CT_RDMEM   = 4'd2,
    CT_WRMEM   = 4'd3,
    CT_RDIO    = 4'd4,
    CT_WRIO    = 4'd5,
    CT_INTA    = 4'd6
  } e_cyc_type;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbFetch = 2'd1,
    ArbData  = 2'd2,
    ArbHold  = 2'd3
  } e_biu_arb_state;

  // Interrupt acknowledge overrides both direction and address space.
  function automatic e_cyc_type data_cyc_type(input logic we, input logic io, input logic inta);
    e_cyc_type ct;
    if (inta) begin
      ct = CT_INTA;
    end else if (io) begin
      ct = we ? CT_WRIO : CT_RDIO;
    end else begin
      ct = we ? CT_WRMEM : CT_RDMEM;
    end
    return ct;
  endfunction

endpackage

// File: rtl/rf80386_bus_timer.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags expiry at Limit.
module rf80386_bus_timer #(
  parameter int unsigned Limit = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned Width = (Limit < 2) ? 1 : $clog2(Limit + 1);
  localparam logic [Width-1:0] LimitVal = Width'(Limit);

  logic [Width-1:0] count_q;

  // Count enabled cycles, saturating at the limit so expiry stays asserted.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != LimitVal)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expire_o = (count_q == LimitVal);

endmodule

// File: rtl/rf80386_biu_arbiter.sv
// Shares the Wishbone master port between instruction fetch and execution-unit data accesses.
module rf80386_biu_arbiter
  import rf80386_pkg::*;
#(
  parameter int unsigned AWID    = 32,
  parameter int unsigned STARVE  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_req_i,
  input  logic [AWID-1:0] if_adr_i,
  output logic            if_ack_o,
  output logic            if_err_o,
  output logic [31:0]     if_dat_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic            d_io_i,
  input  logic            d_inta_i,
  input  logic            d_lock_i,
  input  logic [3:0]      d_sel_i,
  input  logic [AWID-1:0] d_adr_i,
  input  logic [31:0]     d_dat_i,
  output logic            d_ack_o,
  output logic            d_err_o,
  output logic [31:0]     d_dat_o,
  output logic            cyc_o,
  output logic            stb_o,
  output logic            we_o,
  output logic            lock_o,
  output logic [3:0]      sel_o,
  output logic [AWID-1:0] adr_o,
  output logic [31:0]     dat_o,
  output logic [3:0]      cyc_type_o,
  input  logic [31:0]     dat_i,
  input  logic            ack_i,
  input  logic            err_i
);

  localparam logic [3:0] StarveMax = 4'(STARVE);

  e_biu_arb_state state_q, state_d;
  logic [3:0]     starve_q, starve_d;

  logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d, lock_q, lock_d;
  logic [3:0]      sel_q, sel_d;
  logic [AWID-1:0] adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  e_cyc_type       cyc_type_q, cyc_type_d;
  logic            if_ack_q, if_ack_d, if_err_q, if_err_d;
  logic            d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [31:0]     if_dat_q, if_dat_d, d_dat_q, d_dat_d;

  logic grant_f, grant_d, on_bus, done, bus_err, hold_next, expire;

  rf80386_bus_timer #(
    .Limit(TIMEOUT)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (grant_f | grant_d),
    .enable_i(stb_q),
    .expire_o(expire)
  );

  // A slave response wins over a simultaneous timeout; err_i wins over ack_i.
  assign on_bus    = (state_q == ArbFetch) || (state_q == ArbData);
  assign done      = on_bus & (ack_i | err_i | expire);
  assign bus_err   = err_i | (expire & ~ack_i);
  assign hold_next = (state_q == ArbData) & lock_q & ~bus_err;

  // Grant decision: data has priority unless fetch has waited STARVE data grants.
  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    unique case (state_q)
      ArbIdle: begin
        grant_f = if_req_i & (~d_req_i | (starve_q == StarveMax));
        grant_d = d_req_i & ~grant_f;
      end
      ArbHold: grant_d = d_req_i;
      default: ;
    endcase
  end

  // Fetch fairness counter, only advanced by data grants made from idle.
  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || grant_f) begin
      starve_d = '0;
    end else if (grant_d && (state_q == ArbIdle) && (starve_q != StarveMax)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ArbIdle;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ArbIdle: begin
        if (grant_f) begin
          state_d = ArbFetch;
        end else if (grant_d) begin
          state_d = ArbData;
        end
      end
      ArbFetch: if (done) state_d = ArbIdle;
      ArbData:  if (done) state_d = hold_next ? ArbHold : ArbIdle;
      ArbHold: begin
        if (d_req_i) begin
          state_d = ArbData;
        end else if (!d_lock_i) begin
          state_d = ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  // Next values of the registered bus and requester outputs.
  always_comb begin
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    lock_d     = lock_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    cyc_type_d = cyc_type_q;
    if_ack_d   = 1'b0;
    if_err_d   = 1'b0;
    d_ack_d    = 1'b0;
    d_err_d    = 1'b0;
    if_dat_d   = if_dat_q;
    d_dat_d    = d_dat_q;
    if (grant_f) begin
      cyc_d      = 1'b1;
      stb_d      = 1'b1;
      we_d       = 1'b0;
      lock_d     = 1'b0;
      sel_d      = 4'hF;
      adr_d      = if_adr_i;
      dat_d      = '0;
      cyc_type_d = CT_CODE;
    end else if (grant_d) begin
      cyc_d      = 1'b1;
      stb_d      = 1'b1;
      we_d       = d_we_i & ~d_inta_i;
      lock_d     = d_lock_i;
      sel_d      = d_sel_i;
      adr_d      = d_adr_i;
      dat_d      = d_dat_i;
      cyc_type_d = data_cyc_type(d_we_i, d_io_i, d_inta_i);
    end else if (done) begin
      stb_d      = 1'b0;
      cyc_d      = hold_next;
      lock_d     = hold_next;
      cyc_type_d = CT_PASSIVE;
      if (state_q == ArbFetch) begin
        if_ack_d = ~bus_err;
        if_err_d = bus_err;
        if (!bus_err) if_dat_d = dat_i;
      end else begin
        d_ack_d = ~bus_err;
        d_err_d = bus_err;
        if (!bus_err) d_dat_d = dat_i;
      end
    end else if ((state_q == ArbHold) && !d_lock_i) begin
      cyc_d  = 1'b0;
      lock_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      lock_q     <= 1'b0;
      sel_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      cyc_type_q <= CT_PASSIVE;
      if_ack_q   <= 1'b0;
      if_err_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      d_err_q    <= 1'b0;
      if_dat_q   <= '0;
      d_dat_q    <= '0;
    end else begin
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      lock_q     <= lock_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      cyc_type_q <= cyc_type_d;
      if_ack_q   <= if_ack_d;
      if_err_q   <= if_err_d;
      d_ack_q    <= d_ack_d;
      d_err_q    <= d_err_d;
      if_dat_q   <= if_dat_d;
      d_dat_q    <= d_dat_d;
    end
  end

  assign cyc_o      = cyc_q;
  assign stb_o      = stb_q;
  assign we_o       = we_q;
  assign lock_o     = lock_q;
  assign sel_o      = sel_q;
  assign adr_o      = adr_q;
  assign dat_o      = dat_q;
  assign cyc_type_o = cyc_type_q;
  assign if_ack_o   = if_ack_q;
  assign if_err_o   = if_err_q;
  assign if_dat_o   = if_dat_q;
  assign d_ack_o    = d_ack_q;
  assign d_err_o    = d_err_q;
  assign d_dat_o    = d_dat_q;

endmodule

// File: tb/tb_rf80386_biu_arbiter.sv
// Self-checking bench for rf80386_biu_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_rf80386_biu_arbiter;
  import rf80386_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned ST = 4;
  localparam int unsigned TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          if_req_i;
  logic [AW-1:0] if_adr_i;
  logic          if_ack_o, if_err_o;
  logic [31:0]   if_dat_o;
  logic          d_req_i, d_we_i, d_io_i, d_inta_i, d_lock_i;
  logic [3:0]    d_sel_i;
  logic [AW-1:0] d_adr_i;
  logic [31:0]   d_dat_i;
  logic          d_ack_o, d_err_o;
  logic [31:0]   d_dat_o;
  logic          cyc_o, stb_o, we_o, lock_o;
  logic [3:0]    sel_o;
  logic [AW-1:0] adr_o;
  logic [31:0]   dat_o;
  logic [3:0]    cyc_type_o;
  logic [31:0]   dat_i;
  logic          ack_i, err_i;

  int total = 0;
  int bad   = 0;

  rf80386_biu_arbiter #(
    .AWID   (AW),
    .STARVE (ST),
    .TIMEOUT(TO)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .if_req_i  (if_req_i),
    .if_adr_i  (if_adr_i),
    .if_ack_o  (if_ack_o),
    .if_err_o  (if_err_o),
    .if_dat_o  (if_dat_o),
    .d_req_i   (d_req_i),
    .d_we_i    (d_we_i),
    .d_io_i    (d_io_i),
    .d_inta_i  (d_inta_i),
    .d_lock_i  (d_lock_i),
    .d_sel_i   (d_sel_i),
    .d_adr_i   (d_adr_i),
    .d_dat_i   (d_dat_i),
    .d_ack_o   (d_ack_o),
    .d_err_o   (d_err_o),
    .d_dat_o   (d_dat_o),
    .cyc_o     (cyc_o),
    .stb_o     (stb_o),
    .we_o      (we_o),
    .lock_o    (lock_o),
    .sel_o     (sel_o),
    .adr_o     (adr_o),
    .dat_o     (dat_o),
    .cyc_type_o(cyc_type_o),
    .dat_i     (dat_i),
    .ack_i     (ack_i),
    .err_i     (err_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [3:0] exp_type(input logic we, input logic io, input logic inta);
    if (inta) return CT_INTA;
    if (io) return we ? CT_WRIO : CT_RDIO;
    return we ? CT_WRMEM : CT_RDMEM;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic clear_inputs();
    if_req_i = 0; if_adr_i = '0;
    d_req_i = 0; d_we_i = 0; d_io_i = 0; d_inta_i = 0; d_lock_i = 0;
    d_sel_i = '0; d_adr_i = '0; d_dat_i = '0;
    dat_i = '0; ack_i = 0; err_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1;
    tick();
    tick();
    rst_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({cyc_o, stb_o, we_o, lock_o, sel_o, adr_o, dat_o, if_ack_o, if_err_o, d_ack_o, d_err_o,
         if_dat_o, d_dat_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: cyc=%b stb=%b we=%b lock=%b sel=%h adr=%h dat=%h, want all 0",
               cyc_o, stb_o, we_o, lock_o, sel_o, adr_o, dat_o);
    end
    total++;
    if (cyc_type_o !== CT_PASSIVE) begin
      bad++;
      $display("FAIL reset_cyc_type: got %0d want %0d", cyc_type_o, CT_PASSIVE);
    end
    // Slave responses with no cycle in progress must be ignored.
    ack_i = 1; err_i = 1;
    tick();
    tick();
    total++;
    if ({cyc_o, stb_o, if_ack_o, if_err_o, d_ack_o, d_err_o} !== 6'b0) begin
      bad++;
      $display("FAIL idle_noise: got %b want 000000",
               {cyc_o, stb_o, if_ack_o, if_err_o, d_ack_o, d_err_o});
    end
    ack_i = 0; err_i = 0;
  endtask

  task automatic test_fetch();
    do_reset();
    if_req_i = 1; if_adr_i = 32'h000F_0000;
    tick();
    total++;
    if ({cyc_o, stb_o, we_o, sel_o, adr_o, cyc_type_o} !==
        {1'b1, 1'b1, 1'b0, 4'hF, 32'h000F_0000, CT_CODE}) begin
      bad++;
      $display("FAIL fetch_start: cyc=%b stb=%b we=%b sel=%h adr=%h ct=%0d want 1 1 0 f f0000 1",
               cyc_o, stb_o, we_o, sel_o, adr_o, cyc_type_o);
    end
    tick();
    ack_i = 1; dat_i = 32'h9090_9090;
    tick();
    total++;
    if ({if_ack_o, if_err_o, d_ack_o, if_dat_o, cyc_o, stb_o, cyc_type_o} !==
        {1'b1, 1'b0, 1'b0, 32'h9090_9090, 1'b0, 1'b0, CT_PASSIVE}) begin
      bad++;
      $display("FAIL fetch_done: ack=%b err=%b dack=%b dat=%h cyc=%b stb=%b ct=%0d want 1 0 0 90909090 0 0 0",
               if_ack_o, if_err_o, d_ack_o, if_dat_o, cyc_o, stb_o, cyc_type_o);
    end
    if_req_i = 0; ack_i = 0; dat_i = 32'h1111_1111;
    tick();
    total++;
    if ({if_ack_o, stb_o, if_dat_o} !== {1'b0, 1'b0, 32'h9090_9090}) begin
      bad++;
      $display("FAIL fetch_pulse: ack=%b stb=%b dat=%h want 0 0 90909090", if_ack_o, stb_o, if_dat_o);
    end
  endtask

  task automatic test_fairness();
    string got, exp;
    int cnt, n;
    do_reset();
    got = ""; exp = ""; cnt = 0; n = 0;
    for (int i = 0; i < 10; i++) begin
      if (cnt == ST) begin
        exp = {exp, "F"}; cnt = 0;
      end else begin
        exp = {exp, "D"}; cnt = cnt + 1;
      end
    end
    if_req_i = 1; if_adr_i = 32'h100;
    d_req_i = 1; d_adr_i = 32'h200; d_sel_i = 4'hF;
    ack_i = 1; dat_i = 32'h5A5A_5A5A;
    for (int c = 0; c < 60; c++) begin
      if (n < 10) begin
        tick();
        if (stb_o) begin
          if (cyc_type_o == CT_CODE) got = {got, "F"};
          else got = {got, "D"};
          n++;
        end
      end
    end
    if_req_i = 0; d_req_i = 0;
    tick();
    ack_i = 0;
    tick();
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL fairness_order: got %s want %s", got, exp);
    end
  endtask

  task automatic test_lock();
    logic hold_ok;
    do_reset();
    if_req_i = 1; if_adr_i = 32'h1000;
    d_req_i = 1; d_lock_i = 1; d_we_i = 0; d_adr_i = 32'h2000; d_sel_i = 4'hF;
    tick();
    total++;
    if ({stb_o, lock_o, cyc_type_o} !== {1'b1, 1'b1, CT_RDMEM}) begin
      bad++;
      $display("FAIL lock_read_start: stb=%b lock=%b ct=%0d want 1 1 2", stb_o, lock_o, cyc_type_o);
    end
    ack_i = 1; dat_i = 32'hCAFE_F00D;
    tick();
    total++;
    if ({d_ack_o, d_dat_o, cyc_o, stb_o, lock_o} !== {1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL lock_read_done: ack=%b dat=%h cyc=%b stb=%b lock=%b want 1 cafef00d 1 0 1",
               d_ack_o, d_dat_o, cyc_o, stb_o, lock_o);
    end
    d_req_i = 0; ack_i = 0;
    hold_ok = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!(cyc_o === 1'b1 && stb_o === 1'b0 && lock_o === 1'b1 && if_ack_o === 1'b0)) hold_ok = 0;
    end
    total++;
    if (hold_ok !== 1'b1) begin
      bad++;
      $display("FAIL lock_hold: cyc=%b stb=%b lock=%b ifack=%b want 1 0 1 0",
               cyc_o, stb_o, lock_o, if_ack_o);
    end
    d_req_i = 1; d_we_i = 1; d_lock_i = 0; d_adr_i = 32'h2004; d_dat_i = 32'h1234_5678;
    tick();
    total++;
    if ({cyc_o, stb_o, lock_o, we_o, cyc_type_o, adr_o, dat_o} !==
        {1'b1, 1'b1, 1'b0, 1'b1, CT_WRMEM, 32'h2004, 32'h1234_5678}) begin
      bad++;
      $display("FAIL lock_write_start: cyc=%b stb=%b lock=%b we=%b ct=%0d adr=%h dat=%h",
               cyc_o, stb_o, lock_o, we_o, cyc_type_o, adr_o, dat_o);
    end
    ack_i = 1;
    tick();
    total++;
    if ({d_ack_o, cyc_o, lock_o} !== 3'b100) begin
      bad++;
      $display("FAIL lock_write_done: ack=%b cyc=%b lock=%b want 1 0 0", d_ack_o, cyc_o, lock_o);
    end
    d_req_i = 0; ack_i = 0;
    tick();
    total++;
    if ({stb_o, cyc_type_o, adr_o} !== {1'b1, CT_CODE, 32'h1000}) begin
      bad++;
      $display("FAIL lock_fetch_after: stb=%b ct=%0d adr=%h want 1 1 1000", stb_o, cyc_type_o, adr_o);
    end
    ack_i = 1;
    tick();
    if_req_i = 0; ack_i = 0;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    logic found;
    do_reset();
    d_req_i = 1; d_lock_i = 1; d_adr_i = 32'h4000; d_sel_i = 4'hF;
    tick();
    n = 0; found = 0;
    for (int i = 0; i < 40; i++) begin
      if (!found) begin
        tick();
        n++;
        if (d_err_o) found = 1;
      end
    end
    total++;
    if (!found || n != TO + 1) begin
      bad++;
      $display("FAIL timeout_latency: err after %0d clocks (seen=%b) want %0d", n, found, TO + 1);
    end
    d_req_i = 0; d_lock_i = 0;
    total++;
    if ({lock_o, cyc_o, stb_o, d_ack_o, cyc_type_o} !== {4'b0, CT_PASSIVE}) begin
      bad++;
      $display("FAIL timeout_release: lock=%b cyc=%b stb=%b ack=%b ct=%0d want 0 0 0 0 0",
               lock_o, cyc_o, stb_o, d_ack_o, cyc_type_o);
    end
    tick();
    total++;
    if ({d_err_o, cyc_o} !== 2'b00) begin
      bad++;
      $display("FAIL timeout_idle: err=%b cyc=%b want 0 0", d_err_o, cyc_o);
    end
  endtask

  task automatic test_io_err();
    do_reset();
    d_req_i = 1; d_io_i = 1; d_we_i = 1; d_sel_i = 4'h3; d_adr_i = 32'h3F8; d_dat_i = 32'h41;
    tick();
    total++;
    if ({stb_o, we_o, sel_o, adr_o, dat_o, cyc_type_o} !==
        {1'b1, 1'b1, 4'h3, 32'h3F8, 32'h41, CT_WRIO}) begin
      bad++;
      $display("FAIL io_write_start: stb=%b we=%b sel=%h adr=%h dat=%h ct=%0d want 1 1 3 3f8 41 5",
               stb_o, we_o, sel_o, adr_o, dat_o, cyc_type_o);
    end
    ack_i = 1; err_i = 1; dat_i = 32'hDEAD_BEEF;
    tick();
    total++;
    if ({d_err_o, d_ack_o, d_dat_o, stb_o} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL ack_err_both: err=%b ack=%b dat=%h stb=%b want 1 0 0 0",
               d_err_o, d_ack_o, d_dat_o, stb_o);
    end
    d_req_i = 0; ack_i = 0; err_i = 0;
    tick();
    d_req_i = 1; d_inta_i = 1; d_we_i = 1; d_io_i = 1;
    tick();
    total++;
    if ({stb_o, we_o, cyc_type_o} !== {1'b1, 1'b0, CT_INTA}) begin
      bad++;
      $display("FAIL inta_start: stb=%b we=%b ct=%0d want 1 0 6", stb_o, we_o, cyc_type_o);
    end
    ack_i = 1; dat_i = 32'h0000_0008;
    tick();
    total++;
    if ({d_ack_o, d_err_o, d_dat_o} !== {1'b1, 1'b0, 32'h8}) begin
      bad++;
      $display("FAIL inta_done: ack=%b err=%b dat=%h want 1 0 8", d_ack_o, d_err_o, d_dat_o);
    end
    d_req_i = 0; d_inta_i = 0; ack_i = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_req_i = 1; d_we_i = 1; d_lock_i = 1; d_adr_i = 32'h8888; d_dat_i = 32'h7777; d_sel_i = 4'hF;
    tick();
    total++;
    if (stb_o !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pre: stb=%b want 1", stb_o);
    end
    rst_i = 1; ack_i = 1; dat_i = 32'hABCD;
    tick();
    total++;
    if ({cyc_o, stb_o, we_o, lock_o, sel_o, adr_o, dat_o, cyc_type_o, if_ack_o, if_err_o, d_ack_o,
         d_err_o, d_dat_o} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: cyc=%b stb=%b lock=%b ct=%0d ack=%b err=%b dat=%h want all 0",
               cyc_o, stb_o, lock_o, cyc_type_o, d_ack_o, d_err_o, d_dat_o);
    end
    rst_i = 0; ack_i = 0; d_req_i = 0; d_lock_i = 0;
    tick();
    total++;
    if ({d_ack_o, d_err_o, cyc_o} !== 3'b000) begin
      bad++;
      $display("FAIL midreset_after: ack=%b err=%b cyc=%b want 0 0 0", d_ack_o, d_err_o, cyc_o);
    end
  endtask

  task automatic test_random();
    logic pf, pd, busy, edone, eerr;
    logic [31:0] f_adr, r_adr, r_dat, edat;
    logic [3:0] r_sel;
    logic r_we, r_io, r_inta;
    int who, ewho, eg, starve, wait_left, k;
    logic [3:0] exp_vec;
    do_reset();
    pf = 0; pd = 0; busy = 0; edone = 0; eerr = 0; eg = 0; who = 0; ewho = 0;
    starve = 0; wait_left = 0;
    f_adr = '0; r_adr = '0; r_dat = '0; r_sel = 4'hF; r_we = 0; r_io = 0; r_inta = 0; edat = '0;
    for (int c = 0; c < 600; c++) begin
      if (eg == 1) begin
        total++;
        if ({stb_o, cyc_o, we_o, sel_o, adr_o, cyc_type_o} !==
            {1'b1, 1'b1, 1'b0, 4'hF, f_adr, CT_CODE}) begin
          bad++;
          $display("FAIL rand_fetch_grant c=%0d: stb=%b we=%b sel=%h adr=%h ct=%0d want adr=%h ct=1",
                   c, stb_o, we_o, sel_o, adr_o, cyc_type_o, f_adr);
        end
      end else if (eg == 2) begin
        total++;
        if ({stb_o, cyc_o, we_o, sel_o, adr_o, cyc_type_o} !==
            {1'b1, 1'b1, r_we & ~r_inta, r_sel, r_adr, exp_type(r_we, r_io, r_inta)}) begin
          bad++;
          $display("FAIL rand_data_grant c=%0d: stb=%b we=%b sel=%h adr=%h ct=%0d want %b %h %h %0d",
                   c, stb_o, we_o, sel_o, adr_o, cyc_type_o, r_we & ~r_inta, r_sel, r_adr,
                   exp_type(r_we, r_io, r_inta));
        end
        if (r_we && !r_inta) begin
          total++;
          if (dat_o !== r_dat) begin
            bad++;
            $display("FAIL rand_wdata c=%0d: got %h want %h", c, dat_o, r_dat);
          end
        end
      end
      if (eg != 0) wait_left = $urandom_range(0, 3);
      exp_vec = '0;
      if (edone) exp_vec = (ewho == 1) ? {~eerr, eerr, 2'b00} : {2'b00, ~eerr, eerr};
      total++;
      if ({if_ack_o, if_err_o, d_ack_o, d_err_o} !== exp_vec) begin
        bad++;
        $display("FAIL rand_response c=%0d: if_ack/err d_ack/err=%b want %b", c,
                 {if_ack_o, if_err_o, d_ack_o, d_err_o}, exp_vec);
      end
      if (edone && !eerr) begin
        total++;
        if (((ewho == 1) ? if_dat_o : d_dat_o) !== edat) begin
          bad++;
          $display("FAIL rand_rdata c=%0d: got %h want %h", c,
                   (ewho == 1) ? if_dat_o : d_dat_o, edat);
        end
      end
      total++;
      if (stb_o !== busy) begin
        bad++;
        $display("FAIL rand_stb c=%0d: got %b want %b", c, stb_o, busy);
      end
      // Requesters: drop a completed request, then maybe issue a new one.
      if (edone && ewho == 1) pf = 0;
      if (edone && ewho == 2) pd = 0;
      if (!pf && $urandom_range(0, 1) == 1) begin
        pf = 1; f_adr = $urandom;
      end
      if (!pd && $urandom_range(0, 1) == 1) begin
        pd = 1; r_adr = $urandom; r_dat = $urandom; r_sel = 4'($urandom_range(1, 15));
        r_we = 1'($urandom_range(0, 1)); r_io = 1'($urandom_range(0, 1));
        r_inta = ($urandom_range(0, 7) == 0);
      end
      if_req_i = pf; if_adr_i = f_adr;
      d_req_i = pd; d_adr_i = r_adr; d_dat_i = r_dat; d_sel_i = r_sel;
      d_we_i = r_we; d_io_i = r_io; d_inta_i = r_inta; d_lock_i = 0;
      // Slave: random latency and response; random noise while no strobe.
      if (busy) begin
        if (wait_left == 0) begin
          k = $urandom_range(0, 7);
          ack_i = (k != 0); err_i = (k <= 1); dat_i = $urandom;
        end else begin
          ack_i = 0; err_i = 0; wait_left--;
        end
      end else begin
        ack_i = 1'($urandom_range(0, 1)); err_i = ($urandom_range(0, 3) == 0); dat_i = $urandom;
      end
      // Reference prediction for the coming edge.
      eg = 0; edone = 0;
      if (busy) begin
        if (ack_i || err_i) begin
          edone = 1; eerr = err_i; ewho = who; edat = dat_i; busy = 0;
        end
      end else if (pf || pd) begin
        if (pf && (!pd || starve == ST)) begin
          eg = 1; who = 1;
        end else begin
          eg = 2; who = 2;
        end
        busy = 1;
      end
      if (!pf) starve = 0;
      else if (eg == 1) starve = 0;
      else if (eg == 2) starve = (starve < ST) ? starve + 1 : ST;
      tick();
    end
    if_req_i = 0; d_req_i = 0; err_i = 0; ack_i = 1;
    for (int i = 0; i < 6; i++) tick();
    ack_i = 0;
    tick();
  endtask

  initial begin
    clear_inputs();
    rst_i = 1;
    test_reset();
    test_fetch();
    test_fairness();
    test_lock();
    test_timeout();
    test_io_err();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
